// File: rtl/apb_stream_fifo.sv
// apb_stream_fifo: APB slave bridging a TX FIFO (APB writes -> stream out)
// and an RX FIFO (stream in -> APB reads). Each transfer takes one wait state.
// Optional feature: define APB_STREAM_FIFO_IRQ_EN to add a registered irq output.
module apb_stream_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [3:0]        PADDR,
    input  logic [31:0]       PWDATA,
    input  logic              PWRITE,
    input  logic              PENABLE,
    input  logic              PSEL,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
`ifdef APB_STREAM_FIFO_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_TXDATA = 2'd1,
        REG_RXDATA = 2'd2,
        REG_CTRL   = 2'd3
    } reg_e;

    reg_e reg_sel;
    assign reg_sel = reg_e'(PADDR[3:2]);

    // APB handshake decode
    logic access, wr_done, rd_done;
    assign access  = PSEL & PENABLE & ~PREADY;
    assign wr_done = PSEL & PENABLE & PREADY & PWRITE;
    assign rd_done = PSEL & PENABLE & PREADY & ~PWRITE;

    logic ctrl_wr, tx_flush, rx_flush, clr_flags;
    assign ctrl_wr   = wr_done && (reg_sel == REG_CTRL);
    assign tx_flush  = ctrl_wr & PWDATA[0];
    assign rx_flush  = ctrl_wr & PWDATA[1];
    assign clr_flags = ctrl_wr & PWDATA[2];

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [DATA_W-1:0] rx_mem [DEPTH];
    logic [PTR_W-1:0]  tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CNT_W-1:0]  tx_count, rx_count;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic              tx_ovf, rx_udf, rd_udf;
    logic [1:0]        ctrl_en;
    logic [31:0]       rd_data;

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == CNT_W'(DEPTH));
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == CNT_W'(DEPTH));

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rd_ptr];
    assign rx_ready = ~rx_full;

    logic tx_wr, tx_push, tx_pop, rx_rd, rx_push, rx_pop;
    assign tx_wr   = wr_done && (reg_sel == REG_TXDATA);
    assign tx_push = tx_wr & ~tx_full;
    assign tx_pop  = tx_valid & tx_ready;
    assign rx_push = rx_valid & rx_ready;
    assign rx_rd   = rd_done && (reg_sel == REG_RXDATA);
    // rd_udf was captured when PRDATA was loaded, so the pop matches the data returned.
    assign rx_pop  = rx_rd & ~rd_udf;

    // TX FIFO pointers and occupancy; flush overrides any push/pop
    always_ff @(posedge PCLK) begin
        if (PRESET || tx_flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            tx_count <= tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
        end
    end

    // RX FIFO pointers and occupancy; flush overrides any push/pop
    always_ff @(posedge PCLK) begin
        if (PRESET || rx_flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            rx_count <= rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);
        end
    end

    // FIFO data arrays
    // NOTE: storage is not reset; the counts alone define which entries are valid.
    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= PWDATA[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    end

    // Sticky error flags and CTRL enables; a new error beats a same-cycle clear
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_ovf  <= 1'b0;
            rx_udf  <= 1'b0;
            ctrl_en <= 2'b00;
        end else begin
            if (tx_wr && tx_full)     tx_ovf <= 1'b1;
            else if (clr_flags)       tx_ovf <= 1'b0;
            if (rx_rd && rd_udf)      rx_udf <= 1'b1;
            else if (clr_flags)       rx_udf <= 1'b0;
            if (ctrl_wr)              ctrl_en <= PWDATA[5:4];
        end
    end

    // Read data mux for the addressed register
    // NOTE: default assigned first so no path leaves rd_data unassigned (no latch).
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_STATUS: rd_data = {8'h00, 8'(rx_count), 8'(tx_count), 2'b00,
                                   rx_udf, tx_ovf, tx_empty, rx_full, tx_full, rx_empty};
            REG_RXDATA: if (!rx_empty) rd_data = 32'(rx_mem[rx_rd_ptr]);
            REG_CTRL:   rd_data = {26'd0, ctrl_en, 4'b0000};
            default:    rd_data = '0;
        endcase
    end

    // APB response: one wait state, PRDATA loaded as PREADY rises
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PREADY <= 1'b0;
            PRDATA <= '0;
            rd_udf <= 1'b0;
        end else begin
            PREADY <= access;
            if (access) rd_udf <= rx_empty;
            if (access && !PWRITE) PRDATA <= rd_data;
        end
    end

`ifdef APB_STREAM_FIFO_IRQ_EN
    // Registered interrupt from enabled FIFO conditions and sticky errors
    always_ff @(posedge PCLK) begin
        if (PRESET) irq <= 1'b0;
        else        irq <= (ctrl_en[0] & ~rx_empty) | (ctrl_en[1] & tx_empty) | tx_ovf | rx_udf;
    end
`endif

    // Address LSBs and upper write-data bits are intentionally ignored.
    logic unused;
    assign unused = ^{PADDR[1:0], PWDATA};

endmodule

// File: doc/apb_stream_fifo.md
Name: apb_stream_fifo

Overview:
- Parametrised APB slave with two internal synchronous FIFOs.
- TX FIFO: filled by APB writes, drained by an external valid/ready stream.
- RX FIFO: filled by an external valid/ready stream, drained by APB reads.
- Successor to the fixed 8-bit single-depth APB FIFO interface. Adds configurable width and depth, occupancy counts, sticky error flags, flush and one guaranteed wait state per transfer. Sits between the RISC-V APB bus and serial peripherals such as a UART core.

Parameters:
- DATA_W, 8, stream/FIFO data width, 1..32.
- DEPTH, 16, entries per FIFO; power of two, 2..128.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override).

Ports:
- PCLK  in  1  system clock; all logic rising-edge.
- PRESET  in  1  synchronous, active-high reset.
- PADDR  in  4  byte address; PADDR[3:2] selects register.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  1 = write, 0 = read.
- PENABLE  in  1  APB access phase.
- PSEL  in  1  slave select.
- PRDATA  out  32  read data; valid while PREADY=1.
- PREADY  out  1  transfer completion.
- tx_data  out  DATA_W  head of TX FIFO.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  consumer accepts tx_data.
- rx_data  in  DATA_W  producer data.
- rx_valid  in  1  producer data valid.
- rx_ready  out  1  RX FIFO not full.

Behaviour:
- Reset (PRESET=1 at a PCLK edge):
  - Both FIFOs empty, pointers and counts 0, sticky flags 0, CTRL enables 0.
  - PRDATA=0, PREADY=0, tx_valid=0, rx_ready=1 after release.
  - Reset mid-transfer aborts it: no push/pop occurs and PREADY stays 0.
- APB timing:
  - Access seen (PSEL&PENABLE, PREADY=0) -> PREADY registered 1 on the next cycle, for exactly one cycle. Every transfer therefore has exactly one wait state.
  - Completion cycle = PSEL&PENABLE&PREADY. All register side effects happen at the completion edge only, once per transfer.
  - PREADY is forced 0 in the cycle after a completion, even if PSEL/PENABLE remain high.
- Registers (PADDR[3:2]):
  - 0 STATUS (RO):
    - [0] rx_empty, [1] tx_full, [2] rx_full, [3] tx_empty.
    - [4] tx_ovf sticky, [5] rx_udf sticky.
    - [15:8] tx_count, [23:16] rx_count, zero-extended. Other bits 0.
  - 1 TXDATA (WO):
    - Write pushes PWDATA[DATA_W-1:0].
    - If tx_full at completion, the data is dropped and tx_ovf is set.
    - Read returns 0.
  - 2 RXDATA (RO):
    - Read returns the RX head zero-extended in PRDATA and pops it at completion.
    - If rx_empty, returns 0, no pop, and rx_udf is set.
    - Write is ignored.
  - 3 CTRL:
    - Write bit0 tx_flush, bit1 rx_flush, bit2 clr_flags: write-1 pulses, read as 0.
    - Bits[5:4] are R/W enables, used only with the optional feature.
- PRDATA is registered and loaded in the cycle PREADY rises. It holds its value otherwise.
- Stream side:
  - tx_valid = ~tx_empty; tx_data = TX head with no extra latency. Pop when tx_valid&tx_ready.
  - rx_ready = ~rx_full. Push when rx_valid&rx_ready.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: both occur and the count is unchanged.
  - A push to a full FIFO is rejected even if a pop happens the same cycle.
  - A flush in the same cycle as a push/pop wins: FIFO empty, count 0.
  - clr_flags in the same cycle as a new overflow/underflow: the flag ends up set.
- Pointers wrap modulo DEPTH. Counts saturate naturally at DEPTH and 0.
- Write to the STATUS register is ignored. No PSLVERR.

Optional Feature:
- Macro APB_STREAM_FIFO_IRQ_EN.
- Defined: adds output port irq (1 bit), registered, reset 0.
  - irq = (CTRL[4] & ~rx_empty) | (CTRL[5] & tx_empty) | tx_ovf | rx_udf.
  - Updates one cycle after the source condition changes.
- Undefined: no irq port; CTRL[5:4] still R/W but have no effect.

Test Plan:
- Reset, then read STATUS -> PRDATA=0x0000_0009 (rx_empty, tx_empty), PREADY high on the 2nd access cycle.
- Write TXDATA 0xA5 then 0x3C with tx_ready=0 -> STATUS[15:8]=2. Raise tx_ready -> tx_data 0xA5 then 0x3C, then tx_valid=0.
- DEPTH=16: push 17 TX writes with tx_ready=0 -> tx_full=1, tx_ovf=1, count 16. Write CTRL=0x4 -> tx_ovf=0, count still 16.
- Drive rx_valid with 0x11, 0x22. Read RXDATA twice -> 0x11, 0x22. Third read -> 0, rx_udf=1.
- Same-cycle RX push and APB RXDATA pop at count 5 -> count stays 5. rx_flush with rx_valid=1 -> count 0.
- IRQ_EN defined, CTRL=0x10: an rx push -> irq=1 one cycle later. Pop until empty -> irq=0.
